// File: rtl/branch_pc_if.sv
// rtl/branch_pc_if.sv - control and status bundle between a sequencer and branch_pc
interface branch_pc_if #(
  parameter int D = 12
);
  logic         stall;
  logic         absjump_en;
  logic         reljump_en;
  logic         call_en;
  logic         ret_en;
  logic [D-1:0] target;
  logic [D-1:0] offset;
  logic         err_clr;
  logic [D-1:0] prog_ctr;
  logic         stack_full;
  logic         stack_empty;
  logic         stack_err;

  modport master (
    output stall, absjump_en, reljump_en, call_en, ret_en, target, offset, err_clr,
    input  prog_ctr, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  stall, absjump_en, reljump_en, call_en, ret_en, target, offset, err_clr,
    output prog_ctr, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/branch_pc.sv
// rtl/branch_pc.sv - program counter with jumps, branches and optional return stack (PC_RET_STACK_EN)
module branch_pc #(
  parameter int           D         = 12,
  parameter int           DEPTH     = 4,
  parameter logic [D-1:0] RESET_VEC = '0
) (
  input logic        clk,
  input logic        reset,
  branch_pc_if.slave bus
);

  localparam logic [D-1:0] ONE = D'(1);

  logic [D-1:0] pc_q;
  logic [D-1:0] pc_d;
  logic [D-1:0] pc_inc;
  logic [D-1:0] pc_rel;

  // two's-complement add gives the signed displacement with silent wrap
  assign pc_inc       = pc_q + ONE;
  assign pc_rel       = pc_q + bus.offset;
  assign bus.prog_ctr = pc_q;

`ifdef PC_RET_STACK_EN
  localparam int             AW       = $clog2(DEPTH);
  localparam int             PW       = AW + 1;
  localparam logic [PW-1:0]  FULL_CNT = PW'(DEPTH);

  logic [D-1:0]  mem [DEPTH];
  logic [PW-1:0] sp_q;
  logic [PW-1:0] sp_d;
  logic [PW-1:0] sp_m1;
  logic          full;
  logic          empty;
  logic          err_q;
  logic          err_set;
  logic          push;

  assign sp_m1           = sp_q - PW'(1);
  assign full            = (sp_q == FULL_CNT);
  assign empty           = (sp_q == '0);
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err   = err_q;

  // next pc, pointer and error event by fixed priority; stall freezes everything
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_set = 1'b0;
    push    = 1'b0;
    if (!bus.stall) begin
      if (bus.ret_en) begin
        if (empty) begin
          pc_d    = pc_inc;
          err_set = 1'b1;
        end else begin
          pc_d = mem[sp_m1[AW-1:0]];
          sp_d = sp_m1;
        end
      end else if (bus.call_en) begin
        pc_d = bus.target;
        if (full) begin
          err_set = 1'b1;
        end else begin
          push = 1'b1;
          sp_d = sp_q + PW'(1);
        end
      end else if (bus.absjump_en) begin
        pc_d = bus.target;
      end else if (bus.reljump_en) begin
        pc_d = pc_rel;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // pointer and sticky error; a new error event outranks a same-cycle clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_set | (err_q & ~bus.err_clr);
    end
  end

  // stack storage is never cleared; the pointer alone defines validity
  always_ff @(posedge clk) begin
    if (push && reset) begin
      mem[sp_q[AW-1:0]] <= pc_inc;
    end
  end
`else
  logic unused_ok;

  assign unused_ok       = &{1'b0, bus.ret_en, bus.err_clr};
  assign bus.stack_full  = 1'b0;
  assign bus.stack_empty = 1'b1;
  assign bus.stack_err   = 1'b0;

  // without a stack, call degrades to a jump and return to a plain increment
  always_comb begin
    pc_d = pc_q;
    if (!bus.stall) begin
      if (bus.call_en || bus.absjump_en) begin
        if (bus.ret_en) begin
          pc_d = pc_inc;
        end else begin
          pc_d = bus.target;
        end
      end else if (bus.ret_en) begin
        pc_d = pc_inc;
      end else if (bus.reljump_en) begin
        pc_d = pc_rel;
      end else begin
        pc_d = pc_inc;
      end
    end
  end
`endif

  // program counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_branch_pc.sv
// tb/tb_branch_pc.sv - scoreboard bench for branch_pc with a queue-based reference model
module tb_branch_pc;

  localparam int           D     = 12;
  localparam int           DEPTH = 4;
  localparam int           M     = 1 << D;
  localparam logic [D-1:0] RV    = '0;

  typedef struct packed {
    logic [D-1:0] pc;
    logic         full;
    logic         empty;
    logic         err;
  } exp_t;

  logic clk;
  logic reset;

  branch_pc_if #(.D(D)) bus ();

  branch_pc #(.D(D), .DEPTH(DEPTH), .RESET_VEC(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int    checks;
  int    passes;
  exp_t  exp_q[$];
  string tag_q[$];

  int    m_pc;
  int    m_stk[$];
  bit    m_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model_view();
    exp_t e;
    e.pc    = D'(m_pc);
    e.full  = (m_stk.size() == DEPTH);
    e.empty = (m_stk.size() == 0);
    e.err   = m_err;
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e);
    checks++;
    if (bus.prog_ctr === e.pc && bus.stack_full === e.full &&
        bus.stack_empty === e.empty && bus.stack_err === e.err) begin
      passes++;
    end else begin
      $display("FAIL %s: got pc=%h full=%b empty=%b err=%b, want pc=%h full=%b empty=%b err=%b",
               tag, bus.prog_ctr, bus.stack_full, bus.stack_empty, bus.stack_err,
               e.pc, e.full, e.empty, e.err);
    end
  endtask

  // one clock of stimulus: drive at negedge, advance the model, queue the post-edge state
  task automatic cycle(input bit rst, input bit st, input bit ab, input bit rl, input bit cl,
                       input bit rt, input int tgt, input int off, input bit clr,
                       input string tag);
    bit set;
    int soff;
    @(negedge clk);
    reset          = ~rst;
    bus.stall      = st;
    bus.absjump_en = ab;
    bus.reljump_en = rl;
    bus.call_en    = cl;
    bus.ret_en     = rt;
    bus.target     = D'(tgt);
    bus.offset     = D'(off);
    bus.err_clr    = clr;
    set = 1'b0;
    if (rst) begin
      m_pc = int'(RV);
      m_stk.delete();
      m_err = 1'b0;
      #1;
      compare({tag, "_async"}, model_view());
    end else begin
      if (!st) begin
`ifdef PC_RET_STACK_EN
        if (rt) begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin
            m_pc = (m_pc + 1) % M;
            set  = 1'b1;
          end
        end else if (cl) begin
          if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % M);
          else set = 1'b1;
          m_pc = tgt;
        end
`else
        if (rt && !(cl || ab)) m_pc = (m_pc + 1) % M;
        else if (cl) m_pc = rt ? (m_pc + 1) % M : tgt;
        else if (rt) m_pc = (m_pc + 1) % M;
`endif
        else if (ab) m_pc = tgt;
        else if (rl) begin
          soff = (off >= M / 2) ? off - M : off;
          m_pc = (((m_pc + soff) % M) + M) % M;
        end else m_pc = (m_pc + 1) % M;
      end
`ifdef PC_RET_STACK_EN
      m_err = set | (m_err & !clr);
`endif
    end
    exp_q.push_back(model_view());
    tag_q.push_back(tag);
  endtask

  task automatic idle(input string tag);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic jump(input int a);
    cycle(0, 0, 1, 0, 0, 0, a, 0, 0, "jump");
  endtask

  task automatic call(input int a, input string tag);
    cycle(0, 0, 0, 0, 1, 0, a, 0, 0, tag);
  endtask

  task automatic ret(input string tag);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0, tag);
  endtask

  // monitor: every state change is visible just after the rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) compare(tag_q.pop_front(), exp_q.pop_front());
    end
  end

  initial begin
    checks = 0;
    passes = 0;
    m_pc   = int'(RV);
    m_err  = 1'b0;
    reset  = 1'b0;
    bus.stall = 0; bus.absjump_en = 0; bus.reljump_en = 0; bus.call_en = 0;
    bus.ret_en = 0; bus.target = '0; bus.offset = '0; bus.err_clr = 0;

    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
    cycle(1, 0, 0, 0, 1, 0, 'h123, 0, 0, "reset_hold");
    for (int i = 0; i < 3; i++) idle("idle_inc");

    jump('h010);
    cycle(0, 0, 0, 1, 0, 0, 0, 'hFFC, 0, "rel_neg");
    cycle(0, 0, 0, 1, 0, 0, 0, 'h123, 0, "rel_pos");
    jump('hFFF);
    idle("wrap");

    jump('h020);
    call('h100, "call1");
    idle("sub_inc");
    idle("sub_inc");
    ret("ret1");

    jump('h005);
    for (int i = 0; i < 5; i++) call('h200, "call_fill");
    for (int i = 0; i < 4; i++) ret("ret_drain");
    ret("ret_underflow");
    idle("err_sticky");
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 1, "clr_in_stall");
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 1, "set_and_clr");
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, "clr");

    jump('h040);
    cycle(0, 1, 1, 0, 1, 0, 'h080, 0, 0, "stall_hold");
    cycle(0, 0, 1, 1, 1, 0, 'h080, 'h010, 0, "call_over_abs");
    ret("ret_after_prio");
    call('h300, "call_then_reset");
    cycle(1, 0, 0, 0, 0, 1, 0, 0, 0, "reset_mid_ret");
    idle("post_reset");

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
            $urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
            $urandom_range(M - 1), $urandom_range(M - 1), $urandom_range(7) == 0, "random");
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending, want 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/branch_pc.md
BRANCH_PC -- requirements
Module: branch_pc

Interface
REQ-001 SHALL provide parameter D, default 12, program-counter width in bits.
REQ-002 SHALL provide parameter DEPTH, default 4, return-stack entries (power of two, at least 2).
REQ-003 SHALL provide parameter RESET_VEC, default 0, D-bit value loaded into prog_ctr on reset.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port stall  input  1  hold all state for this cycle.
REQ-007 SHALL have port absjump_en  input  1  absolute jump to target.
REQ-008 SHALL have port reljump_en  input  1  relative branch by offset.
REQ-009 SHALL have port call_en  input  1  push return address, then jump to target.
REQ-010 SHALL have port ret_en  input  1  pop return address into prog_ctr.
REQ-011 SHALL have port target  input  D  absolute or call destination.
REQ-012 SHALL have port offset  input  D  two's-complement signed branch displacement.
REQ-013 SHALL have port err_clr  input  1  clear stack_err.
REQ-014 SHALL have port prog_ctr  output  D  current program counter, registered.
REQ-015 SHALL have port stack_full  output  1  high when DEPTH entries are held.
REQ-016 SHALL have port stack_empty  output  1  high when zero entries are held.
REQ-017 SHALL have port stack_err  output  1  sticky overflow/underflow flag.

Function
REQ-018 SHALL select next prog_ctr by fixed priority: stall > ret_en > call_en > absjump_en > reljump_en > increment.
REQ-019 stall SHALL hold prog_ctr, stack contents, stack pointer and stack_err; err_clr still acts during stall.
REQ-020 Increment SHALL be prog_ctr + 1 modulo 2^D (wrap from all-ones to 0).
REQ-021 Relative branch SHALL be prog_ctr + offset modulo 2^D; offset is sign-interpreted; wrap is silent.
REQ-022 Absolute jump SHALL load target, with latency one cycle (visible on prog_ctr the edge after assertion).
REQ-023 Call SHALL push prog_ctr + 1 (mod 2^D) and load target in the same edge.
REQ-024 Call while stack_full SHALL still load target, drop the push, leave contents unchanged and set stack_err.
REQ-025 Return SHALL load the top entry and pop it in one edge.
REQ-026 Return while stack_empty SHALL increment prog_ctr instead, leave the pointer at 0 and set stack_err.
REQ-027 stack_full/stack_empty SHALL be combinational from the registered pointer (count 0..DEPTH).
REQ-028 stack_err SHALL clear on err_clr; simultaneous set and clear SHALL leave it set.
REQ-029 Unselected lower-priority enables SHALL have no effect in that cycle.

Reset
REQ-030 Assertion (reset low) SHALL immediately force prog_ctr=RESET_VEC, pointer=0, stack_err=0, independent of clk.
REQ-031 Outputs during/after reset: stack_empty=1, stack_full=0; stack entry contents need not be cleared.
REQ-032 Reset mid-call/return SHALL discard the in-flight operation; first post-release edge behaves per REQ-018.

Configuration
REQ-033 Macro PC_RET_STACK_EN defined: return stack and REQ-023..REQ-028 implemented as stated.
REQ-034 Macro PC_RET_STACK_EN undefined: no stack storage; call_en behaves as absjump_en, ret_en behaves as increment, stack_full=0, stack_empty=1, stack_err=0, err_clr ignored.

Verification (D=12, DEPTH=4, RESET_VEC=0, PC_RET_STACK_EN defined unless noted)
REQ-035 Reset low then release, idle 3 cycles -> prog_ctr 0,1,2,3; stack_empty=1.
REQ-036 prog_ctr=0x010, reljump_en, offset=0xFFC -> 0x00C; prog_ctr=0xFFF, increment -> 0x000.
REQ-037 prog_ctr=0x020, call_en target=0x100; then 2 increments; ret_en -> 0x100,0x101,0x102,0x021; stack_empty=1.
REQ-038 Five calls to 0x200 from prog_ctr=0x005 onward -> stack_full after 4th, 5th sets stack_err, prog_ctr=0x200; four returns yield 0x201,0x201,0x201,0x006; fifth ret -> prog_ctr+1, stack_err stays 1 until err_clr.
REQ-039 call_en, absjump_en and stall all high at prog_ctr=0x040 -> prog_ctr stays 0x040, pointer unchanged; drop stall -> call to target wins over absjump.
REQ-040 Macro undefined: call_en target=0x300 -> prog_ctr=0x300; ret_en -> 0x301; stack_err=0 throughout.
